// File: rtl/work_packet_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : work_packet_rx_pkg                                        |
// | Purpose  : Shared definitions for the miner work-intake path:        |
// |            packet geometry, output field widths and the encoding     |
// |            of the UART byte-receiver state machine.                  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package work_packet_rx_pkg;

   // Fixed host protocol: 32 midstate bytes, 20 pad bytes, 12 data2 bytes.
   localparam int PKT_BYTES  = 64;
   localparam int MIDSTATE_W = 256;
   localparam int DATA2_W    = 96;
   localparam int WORD_W     = PKT_BYTES * 8;
   localparam int BYTE_CNT_W = $clog2(PKT_BYTES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

endpackage : work_packet_rx_pkg
`default_nettype wire

// File: rtl/work_packet_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : work_packet_rx_if                                         |
// | Purpose  : Bundle of the serial input and the decoded work-packet    |
// |            outputs of work_packet_rx.                                |
// | Signals  : RxD       serial line, idle high (host -> receiver)       |
// |            midstate  256-bit midstate of last complete packet        |
// |            data2     96-bit tail data of last complete packet        |
// |            rx_rdy    1-cycle pulse, outputs just updated             |
// |            frame_err 1-cycle pulse, stop bit sampled low             |
// |            pkt_abort 1-cycle pulse, partial packet timed out         |
// |            busy      receiver mid-byte or mid-packet                 |
// | Modports : master = host/line side, slave = receiver side            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface work_packet_rx_if;
   import work_packet_rx_pkg::*;

   logic                  RxD;
   logic [MIDSTATE_W-1:0] midstate;
   logic [DATA2_W-1:0]    data2;
   logic                  rx_rdy;
   logic                  frame_err;
   logic                  pkt_abort;
   logic                  busy;

   modport master (
      output RxD,
      input  midstate, data2, rx_rdy, frame_err, pkt_abort, busy
   );

   modport slave (
      input  RxD,
      output midstate, data2, rx_rdy, frame_err, pkt_abort, busy
   );

endinterface : work_packet_rx_if
`default_nettype wire

// File: rtl/work_packet_rx_uart_rx_byte.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_rx_byte                                              |
// | Purpose  : 8N1 UART byte receiver. Synchronises the raw line, finds  |
// |            the start bit, samples 8 data bits LSB first at mid-bit   |
// |            and checks the stop bit.                                  |
// | Ports    : clk          rising-edge clock                            |
// |            rst_n        asynchronous active-low reset                |
// |            i_rxd        raw asynchronous serial line                 |
// |            o_data       received byte (valid with o_byte_valid)      |
// |            o_byte_valid 1-cycle strobe, good stop bit                |
// |            o_frame_err  1-cycle strobe, stop bit sampled low         |
// |            o_active     FSM not idle                                 |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module uart_rx_byte
   import work_packet_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
)(
   input  wire logic       clk,
   input  wire logic       rst_n,
   input  wire logic       i_rxd,
   output logic [7:0]      o_data,
   output logic            o_byte_valid,
   output logic            o_frame_err,
   output logic            o_active
);

   localparam int                 c_CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT/2 - 1);
   localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

   logic               r_sync_meta;
   logic               r_sync;
   rx_state_t          r_state;
   logic [c_CNT_W-1:0] r_bit_cnt;
   logic [2:0]         r_bit_idx;
   logic [7:0]         r_shift;

   rx_state_t          w_state_nxt;
   logic [c_CNT_W-1:0] w_cnt_nxt;
   logic [2:0]         w_idx_nxt;
   logic [7:0]         w_shift_nxt;
   logic               w_byte_valid;
   logic               w_frame_err;

   // Two-flop synchroniser; resets to the idle (high) line level so a
   // reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync_meta <= 1'b1;
         r_sync      <= 1'b1;
      end else begin
         r_sync_meta <= i_rxd;
         r_sync      <= r_sync_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_bit_cnt <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_cnt_nxt;
         r_bit_idx <= w_idx_nxt;
         r_shift   <= w_shift_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_bit_cnt;
      w_idx_nxt    = r_bit_idx;
      w_shift_nxt  = r_shift;
      w_byte_valid = 1'b0;
      w_frame_err  = 1'b0;

      case (r_state)
         IDLE: begin
            w_cnt_nxt = '0;
            if (!r_sync) begin
               w_state_nxt = START;
            end
         end

         // Half a bit later the start bit must still be low; otherwise it
         // was a glitch and is dropped silently.
         START: begin
            if (r_bit_cnt == c_HALF_LAST) begin
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
               w_state_nxt = r_sync ? IDLE : DATA;
            end else begin
               w_cnt_nxt = r_bit_cnt + 1'b1;
            end
         end

         // From mid-start, every full bit period lands on mid-data-bit.
         DATA: begin
            if (r_bit_cnt == c_BIT_LAST) begin
               w_cnt_nxt   = '0;
               w_shift_nxt = {r_sync, r_shift[7:1]};
               w_idx_nxt   = r_bit_idx + 1'b1;
               if (r_bit_idx == 3'd7) begin
                  w_state_nxt = STOP;
               end
            end else begin
               w_cnt_nxt = r_bit_cnt + 1'b1;
            end
         end

         // Leave at mid-stop-bit so the following start edge is not missed.
         // The strobes are combinational so the assembler can register the
         // final byte on the very edge that samples the stop bit.
         STOP: begin
            if (r_bit_cnt == c_BIT_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = IDLE;
               if (r_sync) begin
                  w_byte_valid = 1'b1;
               end else begin
                  w_frame_err = 1'b1;
               end
            end else begin
               w_cnt_nxt = r_bit_cnt + 1'b1;
            end
         end

         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign o_data       = r_shift;
   assign o_byte_valid = w_byte_valid;
   assign o_frame_err  = w_frame_err;
   assign o_active     = (r_state != IDLE);

endmodule : uart_rx_byte
`default_nettype wire

// File: rtl/work_packet_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : work_packet_rx                                            |
// | Purpose  : Work-intake stage for the sha256 miner. Receives one      |
// |            64-byte work packet over UART 8N1, presents midstate and  |
// |            data2 and strobes rx_rdy (start_mining). Drops partial    |
// |            packets on framing errors and on an idle timeout.         |
// | Ports    : clk    dv_clk, rising-edge                                |
// |            rst_n  asynchronous active-low reset                      |
// |            rx_if  slave side of work_packet_rx_if (RxD in; midstate, |
// |                   data2, rx_rdy, frame_err, pkt_abort, busy out)     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module work_packet_rx
   import work_packet_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT   = 434,
   parameter int TIMEOUT_CYCLES = 200000
)(
   input  wire logic         clk,
   input  wire logic         rst_n,
   work_packet_rx_if.slave   rx_if
);

   localparam int                    c_IDLE_W      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_IDLE_W-1:0]   c_TIMEOUT_VAL = c_IDLE_W'(TIMEOUT_CYCLES);
   localparam logic [BYTE_CNT_W-1:0] c_LAST_IDX    = BYTE_CNT_W'(PKT_BYTES - 1);

   logic [7:0] w_byte;
   logic       w_byte_valid;
   logic       w_frame_err;
   logic       w_active;
   logic       w_last_byte;
   logic       w_timeout;

   // Holds the first PKT_BYTES-1 bytes; the final byte is taken straight
   // from the receiver, so the packet is complete on the same edge.
   logic [WORD_W-9:0]     r_word;
   logic [BYTE_CNT_W-1:0] r_byte_cnt;
   logic [c_IDLE_W-1:0]   r_idle_cnt;
   logic [MIDSTATE_W-1:0] r_midstate;
   logic [DATA2_W-1:0]    r_data2;
   logic                  r_rx_rdy;
   logic                  r_frame_err;
   logic                  r_pkt_abort;

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart_rx_byte (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_rxd        (rx_if.RxD),
      .o_data       (w_byte),
      .o_byte_valid (w_byte_valid),
      .o_frame_err  (w_frame_err),
      .o_active     (w_active)
   );

   assign w_last_byte = w_byte_valid && (r_byte_cnt == c_LAST_IDX);
   assign w_timeout   = (r_idle_cnt == c_TIMEOUT_VAL) && (r_byte_cnt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word     <= '0;
         r_byte_cnt <= '0;
      end else if (w_byte_valid) begin
         // A byte arriving on the timeout cycle still counts.
         r_word     <= {r_word[WORD_W-17:0], w_byte};
         r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + 1'b1;
      end else if (w_frame_err || w_timeout) begin
         r_byte_cnt <= '0;
      end
   end

   // Idle counter only runs inside a partial packet and saturates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idle_cnt <= '0;
      end else if (w_byte_valid || (r_byte_cnt == '0)) begin
         r_idle_cnt <= '0;
      end else if (r_idle_cnt != c_TIMEOUT_VAL) begin
         r_idle_cnt <= r_idle_cnt + 1'b1;
      end
   end

   // Packet layout after 64 shifts: byte 0 at the top. Midstate is bytes
   // 0..31, data2 bytes 52..63; pad bytes 32..51 are not looked at.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_midstate <= '0;
         r_data2    <= '0;
      end else if (w_last_byte) begin
         r_midstate <= r_word[WORD_W-9 -: MIDSTATE_W];
         r_data2    <= {r_word[DATA2_W-9:0], w_byte};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_rdy    <= 1'b0;
         r_frame_err <= 1'b0;
         r_pkt_abort <= 1'b0;
      end else begin
         r_rx_rdy    <= w_last_byte;
         r_frame_err <= w_frame_err;
         r_pkt_abort <= w_timeout && !w_byte_valid;
      end
   end

   assign rx_if.midstate  = r_midstate;
   assign rx_if.data2     = r_data2;
   assign rx_if.rx_rdy    = r_rx_rdy;
   assign rx_if.frame_err = r_frame_err;
   assign rx_if.pkt_abort = r_pkt_abort;
   assign rx_if.busy      = w_active || (r_byte_cnt != '0);

endmodule : work_packet_rx
`default_nettype wire

// File: tb/tb_work_packet_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_work_packet_rx                                         |
// | Purpose  : Directed self-checking bench for work_packet_rx with      |
// |            CLKS_PER_BIT=16 and TIMEOUT_CYCLES=2000.                  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_work_packet_rx;
   import work_packet_rx_pkg::*;

   localparam int c_CPB = 16;
   localparam int c_TMO = 2000;

   // Hand-computed packets.
   localparam logic [255:0] c_T1_MID =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [95:0]  c_T1_D2  = 96'h3435363738393a3b3c3d3e3f;
   localparam logic [255:0] c_T4_MID =
      256'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0efeeedecebeae9e8e7e6e5e4e3e2e1e0;
   localparam logic [95:0]  c_T4_D2  = 96'hcbcac9c8c7c6c5c4c3c2c1c0;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   work_packet_rx_if rx_if();

   work_packet_rx #(
      .CLKS_PER_BIT   (c_CPB),
      .TIMEOUT_CYCLES (c_TMO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rx_if (rx_if)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;
   int n_rdy   = 0;
   int n_ferr  = 0;
   int n_abort = 0;
   int cyc     = 0;
   int last_rdy_cyc = 0;
   int stop_cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_if.rx_rdy) begin
         n_rdy++;
         last_rdy_cyc = cyc;
      end
      if (rx_if.frame_err) n_ferr++;
      if (rx_if.pkt_abort) n_abort++;
   end

   task automatic check_val(input string tag, input logic [255:0] obs,
                            input logic [255:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_val);
      rx_if.RxD = 1'b0;
      repeat (c_CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_if.RxD = b[i];
         repeat (c_CPB) @(negedge clk);
      end
      rx_if.RxD = stop_val;
      stop_cyc  = cyc;
      repeat (c_CPB) @(negedge clk);
      rx_if.RxD = 1'b1;
   endtask

   function automatic logic [7:0] pat(input logic [7:0] start,
                                      input logic [7:0] step, input int idx);
      return 8'(int'(start) + idx * int'(step));
   endfunction

   function automatic logic [255:0] exp_mid(input logic [7:0] start,
                                            input logic [7:0] step);
      logic [255:0] r = '0;
      for (int i = 0; i < 32; i++) r = {r[247:0], pat(start, step, i)};
      return r;
   endfunction

   function automatic logic [95:0] exp_d2(input logic [7:0] start,
                                          input logic [7:0] step);
      logic [95:0] r = '0;
      for (int i = 52; i < 64; i++) r = {r[87:0], pat(start, step, i)};
      return r;
   endfunction

   task automatic send_bytes(input logic [7:0] start, input logic [7:0] step,
                             input int n);
      for (int i = 0; i < n; i++) send_byte(pat(start, step, i), 1'b1);
   endtask

   int base_rdy;
   int base_ferr;
   int base_abort;

   initial begin
      rx_if.RxD = 1'b1;
      rst_n     = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_mid",   rx_if.midstate, 256'd0);
      check_val("rst_d2",    256'(rx_if.data2), 256'd0);
      check_val("rst_rdy",   256'(rx_if.rx_rdy), 256'd0);
      check_val("rst_ferr",  256'(rx_if.frame_err), 256'd0);
      check_val("rst_abort", 256'(rx_if.pkt_abort), 256'd0);
      check_val("rst_busy",  256'(rx_if.busy), 256'd0);
      rst_n = 1'b1;
      idle_clks(20);

      // 1: ascending packet 0x00..0x3F
      base_rdy = n_rdy;
      send_bytes(8'h00, 8'h01, 64);
      idle_clks(4);
      check_val("t1_mid", rx_if.midstate, c_T1_MID);
      check_val("t1_d2",  256'(rx_if.data2), 256'(c_T1_D2));
      check_val("t1_rdy_cnt", 256'(n_rdy - base_rdy), 256'd1);
      // Stop bit driven just before edge S; the stop sample reaches the FSM
      // through the 2-flop sync at edge S+10 and rx_rdy is registered there,
      // so it is seen on the falling edge after the 11th rising edge.
      check_val("t1_latency", 256'(last_rdy_cyc - stop_cyc), 256'd11);
      check_val("t1_busy", 256'(rx_if.busy), 256'd0);

      // 2: 5-clock low glitch is rejected
      base_rdy  = n_rdy;
      base_ferr = n_ferr;
      rx_if.RxD = 1'b0;
      idle_clks(5);
      rx_if.RxD = 1'b1;
      idle_clks(2);
      check_val("t2_busy_hi", 256'(rx_if.busy), 256'd1);
      idle_clks(30);
      check_val("t2_busy_lo", 256'(rx_if.busy), 256'd0);
      check_val("t2_rdy_cnt", 256'(n_rdy - base_rdy), 256'd0);
      check_val("t2_ferr_cnt", 256'(n_ferr - base_ferr), 256'd0);
      check_val("t2_mid", rx_if.midstate, c_T1_MID);

      // 3: framing error on byte 5, then a good packet
      base_rdy  = n_rdy;
      base_ferr = n_ferr;
      send_bytes(8'h10, 8'h01, 5);
      send_byte(8'h55, 1'b0);
      idle_clks(3 * c_CPB);
      check_val("t3_ferr_cnt", 256'(n_ferr - base_ferr), 256'd1);
      check_val("t3_busy", 256'(rx_if.busy), 256'd0);
      check_val("t3_mid_hold", rx_if.midstate, c_T1_MID);
      check_val("t3_d2_hold", 256'(rx_if.data2), 256'(c_T1_D2));
      send_bytes(8'h80, 8'h03, 64);
      idle_clks(4);
      check_val("t3_mid", rx_if.midstate, exp_mid(8'h80, 8'h03));
      check_val("t3_d2", 256'(rx_if.data2), 256'(exp_d2(8'h80, 8'h03)));
      check_val("t3_rdy_cnt", 256'(n_rdy - base_rdy), 256'd1);

      // 4: 30 bytes then silence -> abort; next packet 0xFF..0xC0
      base_rdy   = n_rdy;
      base_abort = n_abort;
      send_bytes(8'ha0, 8'h01, 30);
      idle_clks(2100);
      check_val("t4_abort_cnt", 256'(n_abort - base_abort), 256'd1);
      check_val("t4_busy", 256'(rx_if.busy), 256'd0);
      check_val("t4_mid_hold", rx_if.midstate, exp_mid(8'h80, 8'h03));
      check_val("t4_rdy_none", 256'(n_rdy - base_rdy), 256'd0);
      send_bytes(8'hff, 8'hff, 64);
      idle_clks(4);
      check_val("t4_mid", rx_if.midstate, c_T4_MID);
      check_val("t4_d2", 256'(rx_if.data2), 256'(c_T4_D2));
      check_val("t4_rdy_cnt", 256'(n_rdy - base_rdy), 256'd1);
      check_val("t4_abort_once", 256'(n_abort - base_abort), 256'd1);

      // 5: reset in the middle of byte 40
      send_bytes(8'h40, 8'h01, 40);
      rx_if.RxD = 1'b0;
      idle_clks(5);
      rst_n = 1'b0;
      #1;
      check_val("t5_rst_mid",  rx_if.midstate, 256'd0);
      check_val("t5_rst_d2",   256'(rx_if.data2), 256'd0);
      check_val("t5_rst_busy", 256'(rx_if.busy), 256'd0);
      repeat (3) @(negedge clk);
      rx_if.RxD = 1'b1;
      rst_n     = 1'b1;
      idle_clks(40);
      base_rdy = n_rdy;
      send_bytes(8'h21, 8'h05, 64);
      idle_clks(4);
      check_val("t5_mid", rx_if.midstate, exp_mid(8'h21, 8'h05));
      check_val("t5_d2", 256'(rx_if.data2), 256'(exp_d2(8'h21, 8'h05)));
      check_val("t5_rdy_cnt", 256'(n_rdy - base_rdy), 256'd1);

      // 6: two packets back to back
      base_rdy = n_rdy;
      send_bytes(8'h03, 8'h07, 64);
      check_val("t6a_mid", rx_if.midstate, exp_mid(8'h03, 8'h07));
      check_val("t6a_d2", 256'(rx_if.data2), 256'(exp_d2(8'h03, 8'h07)));
      send_bytes(8'hc5, 8'h01, 64);
      idle_clks(4);
      check_val("t6b_mid", rx_if.midstate, exp_mid(8'hc5, 8'h01));
      check_val("t6b_d2", 256'(rx_if.data2), 256'(exp_d2(8'hc5, 8'h01)));
      check_val("t6_rdy_cnt", 256'(n_rdy - base_rdy), 256'd2);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_work_packet_rx
`default_nettype wire
